// File: rtl/mips_ex_muldiv_seq_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer: issue opcodes,
// FSM states and step-datapath modes.
package mips_ex_muldiv_seq_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MFHI  = 3'd6;
  localparam logic [2:0] OP_MFLO  = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

endpackage

// File: rtl/mips_ex_muldiv_step.sv
// One iteration of shift-add multiply or restoring divide; purely combinational,
// zero latency, no flow control.
module mips_ex_muldiv_step
  import mips_ex_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             mode,
  input  logic [WIDTH-1:0] acc_hi_in,
  input  logic [WIDTH-1:0] acc_lo_in,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_hi_out,
  output logic [WIDTH-1:0] acc_lo_out
);

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    // Multiply: acc_hi is the partial product, acc_lo holds the unconsumed multiplier bits.
    add_sum = {1'b0, acc_hi_in} + (acc_lo_in[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    // Divide: acc_hi is the remainder, acc_lo shifts dividend bits out and quotient bits in.
    shifted = {acc_hi_in, acc_lo_in[WIDTH-1]};
    trial   = shifted - {1'b0, opnd};

    if (mode == MODE_MUL) begin
      acc_hi_out = add_sum[WIDTH:1];
      acc_lo_out = {add_sum[0], acc_lo_in[WIDTH-1:1]};
    end else if (!trial[WIDTH]) begin
      acc_hi_out = trial[WIDTH-1:0];
      acc_lo_out = {acc_lo_in[WIDTH-2:0], 1'b1};
    end else begin
      acc_hi_out = shifted[WIDTH-1:0];
      acc_lo_out = {acc_lo_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mips_ex_muldiv_seq.sv
// EX-stage mul/div sequencer owning HI/LO; results land WIDTH+2 cycles after issue.
// Any mul/div-class issue while busy raises stall until the sequencer is idle again.
module mips_ex_muldiv_seq
  import mips_ex_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             issueValid,
  input  logic [2:0]       issueOp,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] mfResult,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic             sa;
  logic             sb;
  logic             div_op;
  logic             div_zero;
  logic [WIDTH-1:0] orig_rs;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;

  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic               signed_op;
  logic [WIDTH-1:0]   mag_rs;
  logic [WIDTH-1:0]   mag_rt;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  mips_ex_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode       (div_op ? MODE_DIV : MODE_MUL),
    .acc_hi_in  (acc_hi),
    .acc_lo_in  (acc_lo),
    .opnd       (opnd),
    .acc_hi_out (step_hi),
    .acc_lo_out (step_lo)
  );

  always_comb begin
    signed_op = (issueOp == OP_MULT) || (issueOp == OP_DIV);
    mag_rs    = (signed_op && rs[WIDTH-1]) ? -rs : rs;
    mag_rt    = (signed_op && rt[WIDTH-1]) ? -rt : rt;

    prod     = {acc_hi, acc_lo};
    prod_fix = (sa ^ sb) ? -prod : prod;
    quo_fix  = (sa ^ sb) ? -acc_lo : acc_lo;
    rem_fix  = sa ? -acc_hi : acc_hi;
  end

  assign stall = issueValid && (state != ST_IDLE);

  always_comb begin
    mfResult = '0;
    if (issueValid && (state == ST_IDLE)) begin
      if (issueOp == OP_MFHI) begin
        mfResult = hi;
      end else if (issueOp == OP_MFLO) begin
        mfResult = lo;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      count    <= '0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      div_op   <= 1'b0;
      div_zero <= 1'b0;
      orig_rs  <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      hi       <= '0;
      lo       <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (issueValid) begin
            case (issueOp)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                sa       <= signed_op && rs[WIDTH-1];
                sb       <= signed_op && rt[WIDTH-1];
                div_op   <= issueOp[1];
                div_zero <= (rt == '0);
                orig_rs  <= rs;
                acc_hi   <= '0;
                // Divider consumes the dividend from acc_lo; multiplier consumes the multiplier.
                acc_lo   <= issueOp[1] ? mag_rs : mag_rt;
                opnd     <= issueOp[1] ? mag_rt : mag_rs;
                count    <= '0;
                state    <= issueOp[1] ? ST_DIV : ST_MUL;
                busy     <= 1'b1;
              end
              OP_MTHI: hi <= rs;
              OP_MTLO: lo <= rs;
              default: ;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          count  <= count + CW'(1);
          if (count == CW'(WIDTH-1)) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (!div_op) begin
            {hi, lo} <= prod_fix;
          end else if (div_zero) begin
            lo <= '1;
            hi <= orig_rs;
          end else begin
            lo <= quo_fix;
            hi <= rem_fix;
          end
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mips_ex_muldiv_seq.md
Name: mips_ex_muldiv_seq

Overview:
Multi-cycle multiply/divide sequencer for the EX stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO issues from the EX stage and runs an iterative one-bit-per-cycle shift-add multiplier or restoring divider. It owns the HI/LO registers and raises a pipeline stall while a dependent instruction waits on an in-flight operation. It sits beside the EX-stage ALU. Its MFHI/MFLO result is muxed into the EX-stage result path.

Parameters:
WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits.

Ports:
clock  input  1  pipeline clock (rising edge).
reset_n  input  1  asynchronous reset, active-low.
flush  input  1  synchronous cancel of the in-flight operation (branch or exception squash).
issueValid  input  1  EX stage presents a mul/div-class instruction this cycle.
issueOp  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
rs  input  WIDTH  forwarded operand 1 (multiplicand, dividend, or MT source).
rt  input  WIDTH  forwarded operand 2 (multiplier or divisor).
stall  output  1  combinational; freezes the IF/ID/EX stages.
busy  output  1  registered; an operation is in flight.
mfResult  output  WIDTH  combinational HI (MFHI) or LO (MFLO); otherwise 0.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, hi=lo=0, busy=0, count=0, internal accumulators=0. A reset during an operation aborts it; hi and lo read 0 afterwards.
- States: IDLE, MUL, DIV, FIX. busy=1 in every state except IDLE.
- IDLE, issueValid with op 0-3:
  - Latch sign flags: sa=rs[W-1] and sb=rt[W-1] for signed ops; both 0 for unsigned ops.
  - Latch unsigned magnitudes |rs| and |rt| (W bits). 0x80000000 becomes magnitude 0x80000000.
  - Set count=0 and go to MUL or DIV. Issuing does not stall.
- MUL: one shift-add step per cycle on a 2W accumulator. After W steps (count=W-1), go to FIX.
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit). After W steps, go to FIX.
- FIX (one cycle), result written to hi/lo at the end of the cycle, then go to IDLE:
  - Multiply: {hi,lo} = product, negated (2W-bit two's complement) if sa^sb.
  - Divide: lo = quotient, negated if sa^sb; hi = remainder, negated if sa.
  - Divide by zero (rt==0 latched at issue), signed or unsigned: lo={W{1}}, hi=original rs, no sign fix.
  - Overflow case DIV 0x80000000/-1: lo=0x80000000, hi=0.
- Latency: issue in cycle 0, steps in cycles 1..W, FIX in cycle W+1. New hi/lo are visible and busy=0 in cycle W+2 (34 cycles for W=32).
- stall = issueValid & (state != IDLE). Any mul/div-class issue while busy stalls, including in the FIX cycle. The stalled instruction is accepted in the first IDLE cycle, so MFHI/MFLO then reads the new value.
- IDLE, issueValid with op 4/5: hi or lo takes rs at the next edge. An MFHI/MFLO in the following cycle sees the new value.
- MFHI/MFLO in IDLE: mfResult = hi or lo from the register, same cycle; no state change.
- flush=1: state goes to IDLE at the next edge, hi/lo unchanged, busy=0 the next cycle.
  - flush wins over a simultaneous issueValid; that issue is dropped (no MT write, no op start).
  - flush in IDLE has no effect.
- issueValid outside ops 0-7 cannot occur (3-bit field); every encoding is defined above.

Decomposition:
- Shared package: issueOp encodings, state encodings, the WIDTH default.
- One natural sub-module: mips_ex_muldiv_step. It is a purely combinational single-iteration datapath selected by mode (shift-add step or restore step). It takes accumulator/remainder, quotient and operand, and returns the next values.
- The sequencer keeps the FSM, counter, sign flags and HI/LO.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> busy high for 33 cycles; in cycle 34, hi=0xFFFFFFFE and lo=0x00000001.
- MULT rs=0xFFFFFFFD (-3) rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV rs=0xFFFFFFF9 (-7) rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV rs=0x80000000 rt=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU rs=5 rt=0 -> lo=0xFFFFFFFF, hi=5.
- MULTU 6*7, then MFLO issued in cycle 1 and held -> stall=1 in cycles 1..33, stall=0 in cycle 34 with mfResult=42.
- MTLO rs=0x1234 in IDLE, then MFLO next cycle -> mfResult=0x1234, stall=0 throughout.
- Start DIVU 100/3, flush at cycle 10 with simultaneous MTHI -> IDLE in cycle 11, hi/lo keep their prior values, MTHI dropped. Repeat the op with reset_n pulsed at cycle 10 -> hi=lo=0 and busy=0 immediately.
